mac_tx_arb: RTL and testbench
=============================

# mac_tx_arb

Frame-atomic round-robin arbiter that shares one `mac_tx` input stream between `N_PORTS` frame sources. It grants one requester at a time and passes its bytes through unchanged. It holds the grant until `mac_tx` reports that the whole frame has left, including pad and FCS. An optional inter-frame gap is inserted before the next grant. It sits directly upstream of `mac_tx`, driving its `in_*` port.

## Interface
- `N_PORTS`, default 4: number of requesters, 2..16.
- `IFG_CYCLES`, default 12: idle cycles enforced after each frame; used only with `MAC_TX_ARB_IFG_EN`. A value of 0 means no gap.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_PORTS: per-port byte valid.
- `req_ready` out N_PORTS: per-port byte accept; at most one bit high.
- `req_data` in N_PORTS*8: port i's byte is `[8i+7:8i]`.
- `req_last` in N_PORTS: last pre-FCS byte of the port's frame.
- `out_valid` out 1: to `mac_tx.in_valid`.
- `out_ready` in 1: from `mac_tx.in_ready`.
- `out_data` out 8: to `mac_tx.in_data`.
- `out_last` out 1: to `mac_tx.in_last`.
- `tx_done` in 1: pulse, equal to `mac_tx` `out_valid & out_ready & out_last`.
- `grant_id` out $clog2(N_PORTS): index of the currently or last granted port.
- `busy` out 1: high in every state except S_IDLE.
- `frame_cnt` out 16: number of completed frames, wraps at 0xFFFF→0.

## Operation
- FSM states: S_IDLE, S_STREAM, S_WAIT_DONE, S_IFG (S_IFG exists only with the macro).
- **S_IDLE**
  - If any `req_valid` is high, pick the winner: the first valid port at or after `rr_ptr`, searching upward with wrap.
  - Register `grant_id` = winner and set `rr_ptr` = winner+1 (mod N_PORTS).
  - Go to S_STREAM.
  - No byte is accepted in S_IDLE.
- **S_STREAM**
  - Combinational passthrough from port g = `grant_id`:
    - `out_valid` = `req_valid[g]`
    - `out_data` = `req_data[g]`
    - `out_last` = `req_last[g]`
    - `req_ready[g]` = `out_ready`
    - all other `req_ready` bits are 0.
  - When `req_valid[g] & out_ready & req_last[g]`, go to S_WAIT_DONE.
- **S_WAIT_DONE**
  - All `req_ready` bits are 0 and `out_valid` is 0.
  - On `tx_done`: increment `frame_cnt`, then go to S_IFG if the macro is set and `IFG_CYCLES` > 0; otherwise go to S_IDLE.
- **S_IFG**
  - Load the gap counter with `IFG_CYCLES`-1 on entry.
  - Decrement every cycle; go to S_IDLE in the cycle the counter equals 0.
- Non-granted ports are never stalled by protocol; they simply see `req_ready` = 0.
- A `tx_done` pulse in S_IDLE, S_STREAM or S_IFG is ignored: `frame_cnt` is unchanged and no state change occurs.
- A requester that drops `req_valid` mid-frame holds the grant; there is no timeout.
- A single-byte frame (`req_last` on the first byte) goes from S_STREAM to S_WAIT_DONE after one accepted byte.

## Timing
- Reset values: state S_IDLE, `rr_ptr` 0, `grant_id` 0, `frame_cnt` 0, gap counter 0. Consequently `req_ready` 0, `out_valid` 0, `out_last` 0, `out_data` 0x00, `busy` 0.
- Arbitration latency: 1 cycle. A request seen in S_IDLE at cycle t can transfer its first byte at cycle t+1.
- Data path: zero latency, combinational valid/ready passthrough in S_STREAM.
- After `tx_done` at cycle t:
  - Without the gap: S_IDLE at t+1, earliest next byte at t+2.
  - With the gap: S_IFG for `IFG_CYCLES` cycles, earliest next byte at t+2+`IFG_CYCLES`.
- Reset asserted mid-frame: all outputs return to reset values immediately. The partial frame is abandoned, so `mac_tx` must share the same reset. `rr_ptr` returns to 0.

## Configuration
- `MAC_TX_ARB_IFG_EN` defined: S_IFG and the gap counter are compiled in, and `IFG_CYCLES` is honoured.
- `MAC_TX_ARB_IFG_EN` undefined: no S_IFG and no gap counter. S_WAIT_DONE goes to S_IDLE on `tx_done`, and `IFG_CYCLES` is ignored.

## Structure
- `mac_tx_arb_pkg` holds:
  - the `arb_state_e` enum
  - the `FRAME_CNT_W` = 16 constant
  - the default `IFG_CYCLES` constant.
- Sub-module `mac_rr_pick`: combinational round-robin picker, taking `req`[N] and `ptr` and returning `gnt_idx` and `any`. It is reusable by future RX-side schedulers.

## Test plan
- Single port 0 sends a 20-byte frame, `IFG_CYCLES`=12 with the macro set:
  - 20 bytes pass through unchanged with `out_last` on byte 20
  - `grant_id` = 0 and `frame_cnt` = 1 after `tx_done`
  - next grant no earlier than 14 cycles after `tx_done`.
- All 4 ports request continuously with 3-byte frames: grant order is 0,1,2,3,0,1, and no port gets two grants in a row.
- Ports 1 and 3 request while `rr_ptr` = 2: port 3 wins, then port 1.
- `out_ready` toggles 1,0,1,0 during a frame:
  - `req_ready[g]` mirrors `out_ready` every cycle
  - all other `req_ready` bits stay 0
  - no byte is lost or duplicated.
- `tx_done` is pulsed spuriously in S_IDLE and in S_STREAM: `frame_cnt` is unchanged and the state is unaffected.
- `rst_n` is asserted during byte 5 of a frame: outputs go to reset values asynchronously, and after release the next request is granted to the lowest valid port at or after index 0.

Source files
------------

// File: rtl/mac_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_tx_arb_pkg
//  Description : Shared types and constants for the mac_tx frame arbiter.
//                MAC_TX_ARB_IFG_EN adds the inter-frame-gap state.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_tx_arb_pkg;

    localparam int FRAME_CNT_W    = 16;
    localparam int DEF_IFG_CYCLES = 12;

`ifdef MAC_TX_ARB_IFG_EN
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_STREAM    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_IFG       = 2'd3
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_STREAM    = 2'd1,
        S_WAIT_DONE = 2'd2
    } arb_state_e;
`endif

endpackage : mac_tx_arb_pkg
`default_nettype wire

// File: rtl/mac_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mac_rr_pick
//  Description : Combinational round-robin picker: first set request at or
//                after ptr, searching upward with wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int W = $clog2(N);

    always_comb begin
        logic found;
        int   idx;
        found   = 1'b0;
        idx     = 0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = W'(idx);
            end
        end
    end

    assign any = |req;

endmodule : mac_rr_pick
`default_nettype wire

// File: rtl/mac_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mac_tx_arb
//  Description : Frame-atomic round-robin arbiter feeding the mac_tx input.
//                Define MAC_TX_ARB_IFG_EN to insert IFG_CYCLES idle cycles
//                after every completed frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_tx_arb
    import mac_tx_arb_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int IFG_CYCLES = DEF_IFG_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PORTS-1:0]         req_valid,
    output logic [N_PORTS-1:0]         req_ready,
    input  logic [N_PORTS*8-1:0]       req_data,
    input  logic [N_PORTS-1:0]         req_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       out_last,
    input  logic                       tx_done,
    output logic [$clog2(N_PORTS)-1:0] grant_id,
    output logic                       busy,
    output logic [FRAME_CNT_W-1:0]     frame_cnt
);

    localparam int GW = $clog2(N_PORTS);

    if (N_PORTS < 2 || N_PORTS > 16) begin : g_bad_nports
        $error("mac_tx_arb: N_PORTS must be 2..16");
    end
    if (IFG_CYCLES < 0) begin : g_bad_ifg
        $error("mac_tx_arb: IFG_CYCLES must be non-negative");
    end

    arb_state_e               state_q, state_d;
    logic [GW-1:0]            grant_q, grant_d;
    logic [GW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                     busy_q, busy_d;
    logic [GW-1:0]            pick_idx;
    logic                     pick_any;
    logic                     last_beat;
    logic [7:0]               port_byte [N_PORTS];

`ifdef MAC_TX_ARB_IFG_EN
    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    logic [IFG_W-1:0]         ifg_cnt_q, ifg_cnt_d;
`endif

    for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
        assign port_byte[i] = req_data[8*i +: 8];
    end

    mac_rr_pick #(
        .N (N_PORTS)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign last_beat = req_valid[grant_q] & out_ready & req_last[grant_q];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        frame_cnt_d = frame_cnt_q;
`ifdef MAC_TX_ARB_IFG_EN
        ifg_cnt_d   = ifg_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    grant_d  = pick_idx;
                    rr_ptr_d = (pick_idx == GW'(N_PORTS - 1)) ? '0 : pick_idx + 1'b1;
                    state_d  = S_STREAM;
                end
            end
            S_STREAM: begin
                if (last_beat) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // Grant is released only once mac_tx has emitted pad and FCS.
                if (tx_done) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
`ifdef MAC_TX_ARB_IFG_EN
                    if (IFG_CYCLES > 0) begin
                        state_d   = S_IFG;
                        ifg_cnt_d = IFG_LOAD;
                    end else begin
                        state_d   = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef MAC_TX_ARB_IFG_EN
            S_IFG: begin
                if (ifg_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q - 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
`ifdef MAC_TX_ARB_IFG_EN
            ifg_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
`ifdef MAC_TX_ARB_IFG_EN
            ifg_cnt_q   <= ifg_cnt_d;
`endif
        end
    end

    // Zero-latency passthrough from the granted port while streaming.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        req_ready = '0;
        if (state_q == S_STREAM) begin
            out_valid          = req_valid[grant_q];
            out_data           = port_byte[grant_q];
            out_last           = req_last[grant_q];
            req_ready[grant_q] = out_ready;
        end
    end

    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule : mac_tx_arb
`default_nettype wire

// File: tb/tb_mac_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_tx_arb
//  Description : Directed self-checking bench for mac_tx_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_tx_arb;

    localparam int N   = 4;
    localparam int IFG = 12;
`ifdef MAC_TX_ARB_IFG_EN
    localparam int GAP = IFG;
`else
    localparam int GAP = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_last;
    logic [8*N-1:0] req_data;
    logic           out_valid, out_ready, out_last, tx_done;
    logic [7:0]     out_data;
    logic [1:0]     grant_id;
    logic           busy;
    logic [15:0]    frame_cnt;

    mac_tx_arb #(.N_PORTS(N), .IFG_CYCLES(IFG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] byte_of(input int p, input int i);
        return 8'(p * 64 + i);
    endfunction

    int len [N];
    int frames_left [N];
    int idx [N];
    int cur, done_cnt, n_grants, exp_frames;
    int exp_order [$];
    bit toggle, spur;

    task automatic idle_inputs();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b1;
        tx_done   = 1'b0;
    endtask

    task automatic run_traffic(input int budget);
        int cyc = 0;
        bit spur_done = 1'b0;
        bit spur_now;
        bit pending;
        cur = -1; done_cnt = 0; n_grants = 0;
        for (int p = 0; p < N; p++) idx[p] = 0;
        pending = 1'b1;
        while (cyc < budget && pending) begin
            @(negedge clk);
            for (int p = 0; p < N; p++) begin
                req_valid[p]        = (frames_left[p] > 0);
                req_data[8*p +: 8]  = byte_of(p, idx[p]);
                req_last[p]         = (idx[p] == len[p] - 1);
            end
            out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            spur_now  = spur && !spur_done && (cur >= 0) && (idx[(cur < 0) ? 0 : cur] == 1);
            if (spur_now) spur_done = 1'b1;
            tx_done = (done_cnt == 1) || spur_now;
            if (done_cnt == 1) exp_frames++;
            if (done_cnt > 0) done_cnt--;
            #1;
            chk("ready_onehot", ($countones(req_ready) <= 1), 1);
            if (cur >= 0) begin
                chk("ready_mirror", req_ready, out_ready ? (32'd1 << cur) : 32'd0);
                chk("busy_stream", busy, 1);
            end
            for (int p = 0; p < N; p++) begin
                if (req_ready[p] && req_valid[p]) begin
                    if (cur < 0) begin
                        chk("grant_order", p, (n_grants < exp_order.size()) ? exp_order[n_grants] : -1);
                        chk("grant_id", grant_id, p);
                        n_grants++;
                        cur = p;
                    end
                    chk("out_valid", out_valid, 1);
                    chk("out_data", out_data, byte_of(p, idx[p]));
                    chk("out_last", out_last, (idx[p] == len[p] - 1));
                    if (idx[p] == len[p] - 1) begin
                        idx[p] = 0;
                        frames_left[p]--;
                        cur = -1;
                        done_cnt = 3;
                    end else begin
                        idx[p]++;
                    end
                end
            end
            cyc++;
            pending = (cur >= 0) || (done_cnt != 0);
            for (int p = 0; p < N; p++) if (frames_left[p] > 0) pending = 1'b1;
        end
        chk("run_in_budget", (cyc < budget), 1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("frame_cnt", frame_cnt, exp_frames);
        chk("grant_count", n_grants, exp_order.size());
    endtask

    task automatic setup(input int l0, l1, l2, l3, input int f0, f1, f2, f3);
        len[0] = l0; len[1] = l1; len[2] = l2; len[3] = l3;
        frames_left[0] = f0; frames_left[1] = f1; frames_left[2] = f2; frames_left[3] = f3;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k, c, w;
        toggle = 1'b0; spur = 1'b0; exp_frames = 0;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 20-byte frame on port 0, then gap measurement with a 1-byte frame
        k = 0; c = 0;
        while (k < 20 && c < 60) begin
            @(negedge clk);
            req_valid[0]   = 1'b1;
            req_data[7:0]  = byte_of(0, k);
            req_last[0]    = (k == 19);
            #1;
            if (c == 0) chk("idle_no_accept", req_ready, 0);
            if (req_ready[0]) begin
                if (k == 0) chk("arb_latency", c, 1);
                chk("f20_data", out_data, byte_of(0, k));
                chk("f20_last", out_last, (k == 19));
                k++;
            end
            c++;
        end
        chk("f20_bytes", k, 20);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("wait_busy", busy, 1);
        chk("wait_no_valid", out_valid, 0);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done       = 1'b0;
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'h5A;
        req_last[0]   = 1'b1;
        #1;
        chk("f20_frame_cnt", frame_cnt, 1);
        chk("f20_grant_id", grant_id, 0);
        w = 1;
        while (!req_ready[0] && w < 40) begin
            @(negedge clk);
            w++;
            #1;
        end
        chk("ifg_gap", w, 2 + GAP);
        chk("single_data", out_data, 8'h5A);
        chk("single_last", out_last, 1);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("single_wait_busy", busy, 1);
        chk("single_wait_ready", req_ready, 0);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        chk("single_frame_cnt", frame_cnt, 2);

        // spurious tx_done in S_IDLE, then in S_STREAM
        repeat (GAP + 2) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        chk("spur_idle_cnt", frame_cnt, 2);
        chk("spur_idle_busy", busy, 0);
        exp_frames = 2;
        spur = 1'b1;
        setup(5, 1, 1, 1, 1, 0, 0, 0);
        exp_order = '{0};
        run_traffic(200);
        spur = 1'b0;

        // all ports requesting continuously with 3-byte frames
        apply_reset();
        exp_frames = 0;
        setup(3, 3, 3, 3, 2, 2, 2, 2);
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        run_traffic(800);

        // steer rr_ptr to 2, then ports 1 and 3 compete
        setup(2, 2, 2, 2, 0, 1, 0, 0);
        exp_order = '{1};
        run_traffic(200);
        setup(2, 2, 2, 2, 0, 1, 0, 1);
        exp_order = '{3, 1};
        run_traffic(300);

        // out_ready toggling mid-frame
        toggle = 1'b1;
        setup(1, 1, 4, 1, 0, 0, 1, 0);
        exp_order = '{2};
        run_traffic(200);
        toggle = 1'b0;

        // asynchronous reset during byte 5 of a port-2 frame
        k = 0; c = 0;
        while (c < 30) begin
            @(negedge clk);
            req_valid          = 4'b0100;
            req_data[23:16]    = byte_of(2, k);
            req_last           = '0;
            #1;
            if (req_ready[2]) begin
                if (k == 4) break;
                k++;
            end
            c++;
        end
        chk("byte5_offered", k, 4);
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", req_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_grant_id", grant_id, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        exp_frames = 0;
        setup(2, 2, 2, 2, 0, 1, 0, 1);
        exp_order = '{1, 3};
        run_traffic(300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mac_tx_arb
`default_nettype wire
